ucode_sequencer: RTL
====================

Name: ucode_sequencer

Overview:
- Table-driven control sequencer that replaces hard-coded per-design control FSMs.
- Holds a writable microprogram of NSTATES entries. On start it steps one entry per clock from state 0 and drives the datapath control word (register loads, mux selects) from the current entry.
- Branches on one selected condition bit (e.g. a condition register output) and stops at a halt entry, raising done.
- Sits beside the datapath; it is programmed by the host/testbench before each run.

Parameters:
- NSTATES, 4, number of microprogram entries (power of two, >=2); SW = clog2(NSTATES)
- CTRL_W, 2, control-word width (concatenated ld/sel signals)
- COND_W, 2, number of condition inputs (>=2); CSW = clog2(COND_W)
- MAX_CYCLES, 255, watchdog limit on cycles per run (>=1); counter width clog2(MAX_CYCLES+1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  run request, sampled only when idle
- cond_in  in  COND_W  datapath condition bits
- prog_we  in  1  microprogram write strobe
- prog_addr  in  SW  entry index for write
- prog_data  in  ENTRY_W  entry, ENTRY_W = 1+2*SW+CSW+CTRL_W; fields MSB->LSB: cont, next1, next0, cond_sel, ctrl
- ctrl_out  out  CTRL_W  control word to datapath
- state_out  out  SW  current microprogram state
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- timeout  out  1  valid with done: run aborted by watchdog
- prog_err  out  1  one-cycle pulse: write attempted while busy

Behaviour:
- Reset (rst=1 at posedge): every table entry cleared to 0 (cont=0 means halt, so an empty table halts immediately); state=0, busy=0, done=0, timeout=0, prog_err=0, cycle counter=0. Reset mid-run aborts without a done pulse.
- ctrl_out = table[state].ctrl while busy=1, else all zeros. Combinational from the state register and the table; zero latency.
- state_out = state register (0 while idle).
- Idle, start=1: at the next edge busy=1, state=0, counter=0. start while busy is ignored.
- Each busy cycle, with E = table[state] and c = cond_in[E.cond_sel] (cond_sel >= COND_W reads 0):
  - E.cont=1: state <= c ? E.next1 : E.next0; counter++.
  - E.cont=0 (halt entry): its ctrl is still driven for this cycle. At the edge: busy<=0, state<=0, done<=1 for one cycle, timeout<=0.
- Unconditional step: next0 == next1.
- Watchdog: if counter reaches MAX_CYCLES while busy on a cont=1 entry, at that edge busy<=0, state<=0, done<=1, timeout<=1. A halt entry takes priority over the watchdog in the same cycle.
- timeout holds its value until the next run starts; done is a pulse.
- prog_we while idle: table[prog_addr] <= prog_data at the edge.
- prog_we while busy: write dropped, prog_err=1 for the next cycle.
- prog_we and start in the same idle cycle: both take effect; the write is visible from the first busy cycle.
- Run latency: N executed entries -> busy high for N cycles, done in cycle N+1 after the start edge.

Test Plan:
- Reset, then start=1 with no programming -> busy 1 cycle, ctrl_out=0, done pulse next cycle, timeout=0.
- Program entry0={1,2,1,cs=0,ctrl=2'b11}, 1={1,0,0,0,2'b10}, 2={0,0,0,0,2'b11}; cond_in[0]=0 -> state_out 0,1,0,1... with ctrl_out 11,10 alternating until watchdog (MAX_CYCLES=255); done+timeout=1 after 255 busy cycles.
- Same program, cond_in[0]=1 -> states 0,2; ctrl_out 11,11; busy 2 cycles; done, timeout=0.
- During a run, prog_we=1 to entry 1 -> prog_err pulse, entry unchanged (rerun gives identical trace).
- Assert rst in busy cycle 2 -> busy=0, state_out=0, ctrl_out=0, no done, table all-halt afterwards.
- start held high for 3 cycles on a 2-entry program -> one run only while busy; a second run begins on the cycle after done if start is still high.

Source files
------------

// File: rtl/ucode_sequencer.sv
// Table-driven control sequencer: steps a writable microprogram one entry per
// clock from entry 0, branching on a selected condition bit until a halt entry.
module ucode_sequencer #(
    parameter int  NSTATES    = 4,
    parameter int  CTRL_W     = 2,
    parameter int  COND_W     = 2,
    parameter int  MAX_CYCLES = 255,
    localparam int SW         = $clog2(NSTATES),
    localparam int CSW        = $clog2(COND_W),
    localparam int ENTRY_W    = 1 + 2*SW + CSW + CTRL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COND_W-1:0]  cond_in,
    input  logic               prog_we,
    input  logic [SW-1:0]      prog_addr,
    input  logic [ENTRY_W-1:0] prog_data,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [SW-1:0]      state_out,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               prog_err
);

    localparam int               CNT_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    fsm_t               fsm_q;
    logic [ENTRY_W-1:0] mem_q [NSTATES];
    logic [SW-1:0]      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic               prog_err_q;

    logic [ENTRY_W-1:0] cur;
    logic               cur_cont;
    logic [SW-1:0]      cur_next1;
    logic [SW-1:0]      cur_next0;
    logic [CSW-1:0]     cur_sel;
    logic [CTRL_W-1:0]  cur_ctrl;
    logic               cur_c;

    // Selectors beyond the implemented condition inputs read as 0.
    function automatic logic pick_cond(input logic [COND_W-1:0] bits,
                                       input logic [CSW-1:0]    sel);
        logic c;
        c = 1'b0;
        for (int i = 0; i < COND_W; i++) begin
            if (sel == CSW'(i)) c = bits[i];
        end
        return c;
    endfunction

    assign cur       = mem_q[state_q];
    assign cur_cont  = cur[ENTRY_W-1];
    assign cur_next1 = cur[CTRL_W+CSW+SW +: SW];
    assign cur_next0 = cur[CTRL_W+CSW +: SW];
    assign cur_sel   = cur[CTRL_W +: CSW];
    assign cur_ctrl  = cur[CTRL_W-1:0];
    assign cur_c     = pick_cond(cond_in, cur_sel);

    assign ctrl_out  = busy_q ? cur_ctrl : '0;
    assign state_out = state_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign prog_err  = prog_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTATES; i++) mem_q[i] <= '0;
            fsm_q      <= S_IDLE;
            state_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            prog_err_q <= 1'b0;

            if (prog_we) begin
                if (busy_q) prog_err_q <= 1'b1;
                else        mem_q[prog_addr] <= prog_data;
            end

            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        fsm_q     <= S_RUN;
                        busy_q    <= 1'b1;
                        state_q   <= '0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Halt wins over the watchdog; the watchdog fires on the
                    // step whose count would bring the counter to MAX_CYCLES.
                    if (!cur_cont) begin
                        fsm_q     <= S_IDLE;
                        busy_q    <= 1'b0;
                        state_q   <= '0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        fsm_q     <= S_IDLE;
                        busy_q    <= 1'b0;
                        state_q   <= '0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q <= cur_c ? cur_next1 : cur_next0;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

endmodule
